pipe_skid_stage: RTL and testbench

Parametrised inter-stage pipeline register for the pipelined processor, replacing fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries a data payload and a control bundle, with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush. Control bits are forced to zero whenever the stage holds no valid entry, so bubbles never assert memW/regW downstream. Sits between any two pipeline stages; the hazard unit drives `flush` and the downstream `out_ready`.

---
 rtl/pipe_stage_pkg.sv | 22 ++
 rtl/pipe_stage_perf.sv | 26 ++
 rtl/pipe_skid_stage.sv | 134 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for generic pipeline stage registers: default widths,
// skid-stage state encoding and control-bundle bit positions.
package pipe_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef logic [1:0] stateT;

  localparam stateT EMPTY = 2'b00;
  localparam stateT ONE   = 2'b01;
  localparam stateT FULL  = 2'b10;

  // Control-bundle bit positions, common to every stage instance
  localparam int unsigned ctrlMemR   = 0;
  localparam int unsigned ctrlMemW   = 1;
  localparam int unsigned ctrlRegW   = 2;
  localparam int unsigned ctrlMemToR = 3;
  localparam int unsigned ctrlPcSel  = 4;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall/flush event counters for a pipeline skid stage.
module pipe_stage_perf #(
  parameter int unsigned CNT_W = pipe_stage_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallEvent,
  input  logic             flushEvent,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] cntMax = {CNT_W{1'b1}};

  // Counters stop at all-ones and are cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallEvent && (stall_cnt != cntMax)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushEvent && (flush_cnt != cntMax)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. Optional counters: PIPE_SKID_STAGE_PERF_CNT_EN.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = pipe_stage_pkg::DATA_W,
  parameter int unsigned CTRL_W = pipe_stage_pkg::CTRL_W
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
  , parameter int unsigned CNT_W = pipe_stage_pkg::CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  import pipe_stage_pkg::*;

  stateT             state, stateNext;
  logic [DATA_W-1:0] mainData, mainDataNext, skidData, skidDataNext;
  logic [CTRL_W-1:0] mainCtrl, mainCtrlNext, skidCtrl, skidCtrlNext;
  logic              inXfer, outXfer;

  assign inXfer  = in_valid & in_ready;
  assign outXfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= stateNext;
  end

  // Next state and slot contents; emptied slots are zeroed so bubbles carry no control
  always_comb begin
    stateNext    = state;
    mainDataNext = mainData;
    mainCtrlNext = mainCtrl;
    skidDataNext = skidData;
    skidCtrlNext = skidCtrl;
    if (flush) begin
      stateNext    = EMPTY;
      mainDataNext = '0;
      mainCtrlNext = '0;
      skidDataNext = '0;
      skidCtrlNext = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            stateNext    = ONE;
            mainDataNext = in_data;
            mainCtrlNext = in_ctrl;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainDataNext = in_data;
            mainCtrlNext = in_ctrl;
          end else if (inXfer) begin
            stateNext    = FULL;
            skidDataNext = in_data;
            skidCtrlNext = in_ctrl;
          end else if (outXfer) begin
            stateNext    = EMPTY;
            mainDataNext = '0;
            mainCtrlNext = '0;
          end
        end
        FULL: begin
          if (outXfer) begin
            stateNext    = ONE;
            mainDataNext = skidData;
            mainCtrlNext = skidCtrl;
            skidDataNext = '0;
            skidCtrlNext = '0;
          end
        end
        default: begin
          stateNext    = EMPTY;
          mainDataNext = '0;
          mainCtrlNext = '0;
          skidDataNext = '0;
          skidCtrlNext = '0;
        end
      endcase
    end
  end

  // Slot storage and registered handshake flags (in_ready held low during reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainData  <= '0;
      mainCtrl  <= '0;
      skidData  <= '0;
      skidCtrl  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      mainData  <= mainDataNext;
      mainCtrl  <= mainCtrlNext;
      skidData  <= skidDataNext;
      skidCtrl  <= skidCtrlNext;
      in_ready  <= (stateNext != FULL);
      out_valid <= (stateNext != EMPTY);
    end
  end

  assign out_data = mainData;
  assign out_ctrl = mainCtrl & {CTRL_W{out_valid}};

`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
  pipe_stage_perf #(
    .CNT_W (CNT_W)
  ) uPerf (
    .clk        (clk),
    .rst        (rst),
    .stallEvent (out_valid & ~out_ready),
    .flushEvent (flush & (state != EMPTY)),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; counter checks build with
// PIPE_SKID_STAGE_PERF_CNT_EN (instance uses CNT_W=2).
module tb_pipe_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
  logic [1:0]    stall_cnt, flush_cnt;
`endif

  int nCmp  = 0;
  int nFail = 0;

  pipe_skid_stage #(
    .DATA_W (DW),
    .CTRL_W (CW)
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
    , .CNT_W (2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    // Fill one entry, then assert reset between edges
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h0F;
    step();
    in_valid = 1'b0;
    nCmp++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    nCmp++; if (out_data !== 32'h0) begin nFail++; $display("FAIL rst_data got=%h exp=0", out_data); end
    nCmp++; if (out_ctrl !== 8'h0) begin nFail++; $display("FAIL rst_ctrl got=%h exp=0", out_ctrl); end
    nCmp++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
    nCmp++; if (stall_cnt !== 2'd0) begin nFail++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    nCmp++; if (flush_cnt !== 2'd0) begin nFail++; $display("FAIL rst_flush_cnt got=%0d exp=0", flush_cnt); end
`endif
    step();
    rst = 1'b1;
    #1;
    nCmp++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL rst_release_in_ready got=%b exp=0", in_ready); end
    step();
    nCmp++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL rst_edge_in_ready got=%b exp=1", in_ready); end
    nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL rst_edge_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
      step();
      nCmp++; if (out_valid !== 1'b1 || out_data !== DW'(i))
        begin nFail++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, DW'(i)); end
      nCmp++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    nCmp++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      begin nFail++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h01;
    step();
    nCmp++; if (out_data !== 32'hA || in_ready !== 1'b1)
      begin nFail++; $display("FAIL stall_1 got d=%h r=%b exp d=a r=1", out_data, in_ready); end
    in_data = 32'hB; in_ctrl = 8'h02;
    step();
    nCmp++; if (out_data !== 32'hA || in_ready !== 1'b0)
      begin nFail++; $display("FAIL stall_2 got d=%h r=%b exp d=a r=0", out_data, in_ready); end
    in_data = 32'hC; in_ctrl = 8'h03;
    step();
    nCmp++; if (out_data !== 32'hA || out_ctrl !== 8'h01 || in_ready !== 1'b0)
      begin nFail++; $display("FAIL stall_3 got d=%h c=%h r=%b exp d=a c=01 r=0", out_data, out_ctrl, in_ready); end
    out_ready = 1'b1;
    step();
    nCmp++; if (out_data !== 32'hB || out_ctrl !== 8'h02 || in_ready !== 1'b1)
      begin nFail++; $display("FAIL stall_resume_b got d=%h c=%h r=%b exp d=b c=02 r=1", out_data, out_ctrl, in_ready); end
    step();
    nCmp++; if (out_data !== 32'hC || out_valid !== 1'b1)
      begin nFail++; $display("FAIL stall_resume_c got d=%h v=%b exp d=c v=1", out_data, out_valid); end
    in_valid = 1'b0;
    step();
    nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL stall_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'hFF;
    step();
    in_data = 32'h22;
    step();
    nCmp++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL flush_full got r=%b exp 0", in_ready); end
    flush = 1'b1; in_data = 32'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    nCmp++; if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || out_data !== 32'h0)
      begin nFail++; $display("FAIL flush_full_clear got v=%b c=%h d=%h exp 0/00/0", out_valid, out_ctrl, out_data); end
    nCmp++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL flush_ready got=%b exp 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL flush_no_emit_%0d got v=%b d=%h exp v=0", i, out_valid, out_data); end
    end
    // Flush from ONE with an input handshake in the same cycle
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h04;
    step();
    flush = 1'b1; in_data = 32'hBEEF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    nCmp++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      begin nFail++; $display("FAIL flush_one got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
    step();
    nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL flush_one_discard got v=%b d=%h exp v=0", out_valid, out_data); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'hFF;
    step();
    in_valid = 1'b0;
    nCmp++; if (out_ctrl !== 8'hFF || out_valid !== 1'b1)
      begin nFail++; $display("FAIL bubble_live got c=%h v=%b exp c=ff v=1", out_ctrl, out_valid); end
    step();
    nCmp++; if (out_ctrl !== 8'h00 || out_valid !== 1'b0)
      begin nFail++; $display("FAIL bubble_zero got c=%h v=%b exp c=00 v=0", out_ctrl, out_valid); end
  endtask

`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
  task automatic test_counters();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h9; in_ctrl = 8'h01;
    step();
    in_valid = 1'b0;
    step(); step();
    nCmp++; if (stall_cnt !== 2'd2) begin nFail++; $display("FAIL cnt_stall_2 got=%0d exp=2", stall_cnt); end
    step(); step(); step();
    nCmp++; if (stall_cnt !== 2'd3) begin nFail++; $display("FAIL cnt_stall_sat got=%0d exp=3", stall_cnt); end
    flush = 1'b1;
    step();
    nCmp++; if (flush_cnt !== 2'd1) begin nFail++; $display("FAIL cnt_flush_held got=%0d exp=1", flush_cnt); end
    step();
    flush = 1'b0;
    nCmp++; if (flush_cnt !== 2'd1) begin nFail++; $display("FAIL cnt_flush_empty got=%0d exp=1", flush_cnt); end
    nCmp++; if (stall_cnt !== 2'd3) begin nFail++; $display("FAIL cnt_stall_hold got=%0d exp=3", stall_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    step();
    nCmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0)
      begin nFail++; $display("FAIL init_reset got v=%b r=%b d=%h exp 0/0/0", out_valid, in_ready, out_data); end
    rst = 1'b1;
    step();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_reset();
`ifdef PIPE_SKID_STAGE_PERF_CNT_EN
    test_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
